// File: rtl/usb_gpx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_gpx_pkg
//  Description : Shared constants for the USB GPX pin conditioner: Avalon-MM
//                register word addresses and edge-type selector encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_gpx_pkg;

  // Avalon-MM word addresses of the conditioner register map
  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,   // RO: filtered GPX level
    ADDR_RSVD = 2'd1,   // RO: reads 0, writes ignored
    ADDR_MASK = 2'd2,   // RW: interrupt mask
    ADDR_EDGE = 2'd3    // W1C: sticky edge capture
  } gpx_addr_e;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage
`default_nettype wire

// File: rtl/usb_gpx_conditioner_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : gpx_glitch_filter
//  Description : Synchronises the raw GPX pin into clk and only lets a new
//                level through after it has been stable for FILTER_CYCLES
//                consecutive cycles.
//  Ports       : clk, reset (sync, active-high), gpx_pin (async raw input),
//                gpx_filtered (registered, debounced level)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpx_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic gpx_pin,
  output logic gpx_filtered
);

  localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   gpx_s;

  always_comb begin
    // Shift the raw pin in at bit 0; the last stage is the synchronised level
    sync_d = {sync_q[SYNC_STAGES-2:0], gpx_pin};
    gpx_s  = sync_q[SYNC_STAGES-1];
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (gpx_s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level has differed for FILTER_CYCLES cycles: accept it
      filt_d = ~filt_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign gpx_filtered = filt_q;

endmodule
`default_nettype wire

// File: rtl/usb_gpx_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : usb_gpx_conditioner
//  Description : Conditions the asynchronous GPX pin from the USB host
//                controller: synchronise + glitch filter, sticky edge capture
//                with mask, level IRQ, and an Avalon-MM slave for software.
//  Ports       : clk, reset (sync, active-high), gpx_pin (raw async pin),
//                address/chipselect/write_n/writedata (Avalon-MM slave in),
//                readdata (registered, 1-cycle latency), gpx_filtered (to
//                GPX PIO in_port), irq (registered level interrupt)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_gpx_conditioner
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int EDGE_TYPE     = EDGE_RISE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        gpx_filtered,
  output logic        irq
);

  gpx_glitch_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .gpx_pin     (gpx_pin),
    .gpx_filtered(gpx_filtered)
  );

  logic        prev_filt_q, prev_filt_d;
  logic        irqmask_q, irqmask_d;
  logic        edgecapture_q, edgecapture_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rise, fall, edge_evt, wr_en, rd_bit;
  logic        unused_wdata;

  // Only bit 0 of the write bus carries information
  assign unused_wdata = ^writedata[31:1];

  always_comb begin
    prev_filt_d = gpx_filtered;
    rise        = gpx_filtered & ~prev_filt_q;
    fall        = ~gpx_filtered & prev_filt_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_evt = fall;
      EDGE_ANY:  edge_evt = rise | fall;
      default:   edge_evt = rise;
    endcase

    wr_en     = chipselect & ~write_n;
    irqmask_d = (wr_en && address == ADDR_MASK) ? writedata[0] : irqmask_q;

    // A new edge outranks a same-cycle W1C so no event is ever lost
    if (edge_evt) begin
      edgecapture_d = 1'b1;
    end else if (wr_en && address == ADDR_EDGE && writedata[0]) begin
      edgecapture_d = 1'b0;
    end else begin
      edgecapture_d = edgecapture_q;
    end

    irq_d = edgecapture_q & irqmask_q;

    case (address)
      ADDR_DATA: rd_bit = gpx_filtered;
      ADDR_MASK: rd_bit = irqmask_q;
      ADDR_EDGE: rd_bit = edgecapture_q;
      default:   rd_bit = 1'b0;
    endcase
    readdata_d = {31'd0, rd_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_filt_q   <= 1'b0;
      irqmask_q     <= 1'b0;
      edgecapture_q <= 1'b0;
      irq_q         <= 1'b0;
      readdata_q    <= '0;
    end else begin
      prev_filt_q   <= prev_filt_d;
      irqmask_q     <= irqmask_d;
      edgecapture_q <= edgecapture_d;
      irq_q         <= irq_d;
      readdata_q    <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire
